// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: immediate extender plus PC-target adder behind a valid/ready
// pipeline stage. SKID_EN=1 gives a two-entry stage whose ready_o comes
// straight from a register. SKID_EN=0 gives a single entry with a
// combinational ready.
`timescale 1ns/1ps
module imm_gen_pipe #(
   parameter int XLEN    = 32,
   parameter bit SKID_EN = 1'b1
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            flush_i,
   input  logic            valid_i,
   output logic            ready_o,
   input  logic [31:0]     instr_i,
   input  logic [2:0]      imm_src_i,
   input  logic [XLEN-1:0] pc_i,
   output logic            valid_o,
   input  logic            ready_i,
   output logic [XLEN-1:0] imm_ext_o,
   output logic [XLEN-1:0] pc_target_o,
   output logic            illegal_o
);

   // Build the immediate at 64 bits, then keep the low XLEN bits.
   // The value is the same for both widths because every format is
   // sign-extended or zero-extended.
   function automatic logic [XLEN-1:0] f_imm_ext(
      input logic [31:0] instr,
      input logic [2:0]  src
   );
      logic [63:0] v;
      case (src)
         3'b000:  v = {{52{instr[31]}}, instr[31:20]};
         3'b001:  v = {{51{instr[31]}}, instr[31], instr[7], instr[30:25],
                       instr[11:8], 1'b0};
         3'b010:  v = {{52{instr[31]}}, instr[31:25], instr[11:7]};
         3'b011:  v = {{32{instr[31]}}, instr[31:12], 12'b0};
         3'b100:  v = {{43{instr[31]}}, instr[31], instr[19:12], instr[20],
                       instr[30:21], 1'b0};
         3'b101:  v = (XLEN == 64) ? {58'b0, instr[25:20]} : {59'b0, instr[24:20]};
         3'b110:  v = {59'b0, instr[19:15]};
         default: v = 64'b0;
      endcase
      return v[XLEN-1:0];
   endfunction

   logic [XLEN-1:0] w_imm_s;
   logic [XLEN-1:0] w_tgt_s;
   logic            w_ill_s;
   logic            w_accept_s;
   logic            w_retire_s;
   logic            w_opcode_unused_s;

   // Main output entry, reached by both stage variants.
   logic            r_valid_r;
   logic [XLEN-1:0] r_imm_r;
   logic [XLEN-1:0] r_tgt_r;
   logic            r_ill_r;

   // The opcode field does not affect the immediate.
   assign w_opcode_unused_s = ^instr_i[6:0];

   // Combinational extension, target add and reserved-format flag.
   always_comb begin
      w_imm_s = f_imm_ext(instr_i, imm_src_i);
      w_tgt_s = pc_i + w_imm_s;
      w_ill_s = (imm_src_i == 3'b111);
   end

   assign w_accept_s  = valid_i && ready_o;
   assign w_retire_s  = r_valid_r && ready_i;
   assign valid_o     = r_valid_r;
   assign imm_ext_o   = r_imm_r;
   assign pc_target_o = r_tgt_r;
   assign illegal_o   = r_ill_r;

   generate
      if (SKID_EN) begin : g_skid
         typedef enum logic [1:0] {
            ST_EMPTY = 2'b00,
            ST_FULL  = 2'b01,
            ST_SKID  = 2'b10
         } state_t;

         state_t          r_state_r;
         logic            r_ready_r;
         logic [XLEN-1:0] r_sk_imm_r;
         logic [XLEN-1:0] r_sk_tgt_r;
         logic            r_sk_ill_r;

         assign ready_o = r_ready_r;

         // Stage FSM: the main entry feeds the output, and the skid entry
         // catches the beat accepted while the output stalls.
         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               r_state_r  <= ST_EMPTY;
               r_ready_r  <= 1'b1;
               r_valid_r  <= 1'b0;
               r_imm_r    <= '0;
               r_tgt_r    <= '0;
               r_ill_r    <= 1'b0;
               r_sk_imm_r <= '0;
               r_sk_tgt_r <= '0;
               r_sk_ill_r <= 1'b0;
            end else if (flush_i) begin
               r_state_r <= ST_EMPTY;
               r_ready_r <= 1'b1;
               r_valid_r <= 1'b0;
            end else begin
               case (r_state_r)
                  ST_EMPTY: begin
                     if (w_accept_s) begin
                        r_imm_r   <= w_imm_s;
                        r_tgt_r   <= w_tgt_s;
                        r_ill_r   <= w_ill_s;
                        r_valid_r <= 1'b1;
                        r_state_r <= ST_FULL;
                     end
                  end
                  ST_FULL: begin
                     if (w_accept_s && w_retire_s) begin
                        r_imm_r <= w_imm_s;
                        r_tgt_r <= w_tgt_s;
                        r_ill_r <= w_ill_s;
                     end else if (w_accept_s) begin
                        r_sk_imm_r <= w_imm_s;
                        r_sk_tgt_r <= w_tgt_s;
                        r_sk_ill_r <= w_ill_s;
                        r_ready_r  <= 1'b0;
                        r_state_r  <= ST_SKID;
                     end else if (w_retire_s) begin
                        r_valid_r <= 1'b0;
                        r_state_r <= ST_EMPTY;
                     end
                  end
                  ST_SKID: begin
                     if (w_retire_s) begin
                        r_imm_r   <= r_sk_imm_r;
                        r_tgt_r   <= r_sk_tgt_r;
                        r_ill_r   <= r_sk_ill_r;
                        r_ready_r <= 1'b1;
                        r_state_r <= ST_FULL;
                     end
                  end
                  default: begin
                     r_state_r <= ST_EMPTY;
                     r_ready_r <= 1'b1;
                     r_valid_r <= 1'b0;
                  end
               endcase
            end
         end
      end else begin : g_single
         assign ready_o = !r_valid_r || ready_i;

         // Single entry: it loads on accept and drains on retire.
         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               r_valid_r <= 1'b0;
               r_imm_r   <= '0;
               r_tgt_r   <= '0;
               r_ill_r   <= 1'b0;
            end else if (flush_i) begin
               r_valid_r <= 1'b0;
            end else if (w_accept_s) begin
               r_valid_r <= 1'b1;
               r_imm_r   <= w_imm_s;
               r_tgt_r   <= w_tgt_s;
               r_ill_r   <= w_ill_s;
            end else if (w_retire_s) begin
               r_valid_r <= 1'b0;
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe. Two DUTs (XLEN=32 and XLEN=64) share the
// same stimulus, and each has its own expected-beat queue.
`timescale 1ns/1ps
module tb_imm_gen_pipe;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        valid = 1'b0;
   logic [31:0] instr = 32'd0;
   logic [2:0]  src = 3'd0;
   logic [63:0] pc64 = 64'd0;
   logic        ready_in = 1'b0;

   logic        rdy32, v32, ill32;
   logic [31:0] imm32, tgt32;
   logic        rdy64, v64, ill64;
   logic [63:0] imm64, tgt64;

   typedef struct packed {
      logic [63:0] imm;
      logic [63:0] tgt;
      logic        ill;
   } exp_t;

   exp_t q32[$];
   exp_t q64[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   imm_gen_pipe #(.XLEN(32), .SKID_EN(1'b1)) dut32 (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(valid),
      .ready_o(rdy32), .instr_i(instr), .imm_src_i(src), .pc_i(pc64[31:0]),
      .valid_o(v32), .ready_i(ready_in), .imm_ext_o(imm32),
      .pc_target_o(tgt32), .illegal_o(ill32));

   imm_gen_pipe #(.XLEN(64), .SKID_EN(1'b1)) dut64 (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(valid),
      .ready_o(rdy64), .instr_i(instr), .imm_src_i(src), .pc_i(pc64),
      .valid_o(v64), .ready_i(ready_in), .imm_ext_o(imm64),
      .pc_target_o(tgt64), .illegal_o(ill64));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] mask(input logic [63:0] v, input int xlen);
      return (xlen == 32) ? {32'd0, v[31:0]} : v;
   endfunction

   // Reference model: each immediate is the signed value of its fields, found with integer arithmetic.
   function automatic logic [63:0] ref_imm(input logic [31:0] in, input logic [2:0] s, input int xlen);
      longint v;
      longint sg;
      sg = in[31] ? 64'sd1 : 64'sd0;
      case (s)
         3'd0: v = -2048 * sg + longint'(in[30:20]);
         3'd1: v = -4096 * sg + 2048 * longint'(in[7]) + 32 * longint'(in[30:25])
                   + 2 * longint'(in[11:8]);
         3'd2: v = -2048 * sg + 32 * longint'(in[30:25]) + longint'(in[11:7]);
         3'd3: v = -64'sd2147483648 * sg + 4096 * longint'(in[30:12]);
         3'd4: v = -1048576 * sg + 4096 * longint'(in[19:12]) + 2048 * longint'(in[20])
                   + 2 * longint'(in[30:21]);
         3'd5: v = (xlen == 64) ? longint'(in[25:20]) : longint'(in[24:20]);
         3'd6: v = longint'(in[19:15]);
         default: v = 64'sd0;
      endcase
      return mask(v, xlen);
   endfunction

   function automatic exp_t ref_beat(input logic [31:0] in, input logic [2:0] s,
                                     input logic [63:0] pc, input int xlen);
      exp_t e;
      e.imm = ref_imm(in, s, xlen);
      e.tgt = mask(mask(pc, xlen) + e.imm, xlen);
      e.ill = (s == 3'd7);
      return e;
   endfunction

   // Drive one cycle of inputs. A beat is recorded as expected if it is accepted.
   task automatic drive(input logic v, input logic [31:0] ins, input logic [2:0] s,
                        input logic [63:0] pc, input logic rdy, input logic fl);
      @(posedge clk);
      #1;
      valid = v; instr = ins; src = s; pc64 = pc; ready_in = rdy; flush = fl;
      #3;
      if (fl) begin
         q32.delete();
         q64.delete();
      end else begin
         if (v && rdy32) q32.push_back(ref_beat(ins, s, pc, 32));
         if (v && rdy64) q64.push_back(ref_beat(ins, s, pc, 64));
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 32'd0, 3'd0, 64'd0, 1'b1, 1'b0);
   endtask

   // Send one beat into an empty stage and return while it is on the output.
   task automatic send_one(input logic [31:0] ins, input logic [2:0] s, input logic [63:0] pc);
      idle(3);
      drive(1'b1, ins, s, pc, 1'b1, 1'b0);
      drive(1'b0, 32'd0, 3'd0, 64'd0, 1'b1, 1'b0);
   endtask

   task automatic mon_port(input string tag, input bit is64, input logic v, input logic r,
                           input logic [63:0] imm, input logic [63:0] tgt, input logic ill);
      int   sz;
      exp_t e;
      sz = is64 ? q64.size() : q32.size();
      chk({tag, "_valid"}, {63'd0, v}, {63'd0, sz > 0});
      chk({tag, "_ready"}, {63'd0, r}, {63'd0, sz < 2});
      if (v && ready_in && sz > 0) begin
         e = is64 ? q64.pop_front() : q32.pop_front();
         chk({tag, "_imm"}, imm, e.imm);
         chk({tag, "_tgt"}, tgt, e.tgt);
         chk({tag, "_ill"}, {63'd0, ill}, {63'd0, e.ill});
      end
   endtask

   // Monitor: checks occupancy and pops retired beats each cycle, away from the clock edge.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (rst_n) begin
            mon_port("x32", 1'b0, v32, rdy32, {32'd0, imm32}, {32'd0, tgt32}, ill32);
            mon_port("x64", 1'b1, v64, rdy64, imm64, tgt64, ill64);
         end
      end
   end

   task automatic chk_reset_state(input string tag);
      chk({tag, "_v32"}, {63'd0, v32}, 64'd0);
      chk({tag, "_r32"}, {63'd0, rdy32}, 64'd1);
      chk({tag, "_imm32"}, {32'd0, imm32}, 64'd0);
      chk({tag, "_tgt32"}, {32'd0, tgt32}, 64'd0);
      chk({tag, "_ill32"}, {63'd0, ill32}, 64'd0);
      chk({tag, "_v64"}, {63'd0, v64}, 64'd0);
      chk({tag, "_r64"}, {63'd0, rdy64}, 64'd1);
      chk({tag, "_imm64"}, imm64, 64'd0);
      chk({tag, "_tgt64"}, tgt64, 64'd0);
   endtask

   initial begin
      // Reset state
      #12;
      chk_reset_state("rst");
      #10;
      rst_n = 1'b1;

      // Test 1: I-type with all ones
      send_one(32'hFFF00093, 3'd0, 64'd0);
      chk("t1_imm", {32'd0, imm32}, 64'h0000_0000_FFFF_FFFF);
      chk("t1_tgt", {32'd0, tgt32}, 64'h0000_0000_FFFF_FFFF);
      chk("t1_valid", {63'd0, v32}, 64'd1);

      // Test 2: negative B-type offset
      send_one(32'hFE000EE3, 3'd1, 64'h100);
      chk("t2_imm", {32'd0, imm32}, 64'h0000_0000_FFFF_FFFC);
      chk("t2_tgt", {32'd0, tgt32}, 64'h0000_0000_0000_00FC);
      chk("t2_ill", {63'd0, ill32}, 64'd0);

      // Test 5: shamt at both widths, then the reserved format
      send_one(32'h03F01013, 3'd5, 64'h40);
      chk("t5_imm32", {32'd0, imm32}, 64'h1F);
      chk("t5_imm64", imm64, 64'h3F);
      send_one(32'h03F01013, 3'd7, 64'h1234_5678_9ABC_DEF0);
      chk("t5r_imm64", imm64, 64'd0);
      chk("t5r_tgt64", tgt64, 64'h1234_5678_9ABC_DEF0);
      chk("t5r_ill", {63'd0, ill64}, 64'd1);

      // Test 3: A, B, C sent while the output stalls
      idle(3);
      drive(1'b1, 32'h00100093, 3'd0, 64'h10, 1'b0, 1'b0);
      drive(1'b1, 32'h00200093, 3'd0, 64'h20, 1'b0, 1'b0);
      drive(1'b1, 32'h00300093, 3'd0, 64'h30, 1'b0, 1'b0);
      chk("t3_hold", {63'd0, rdy32}, 64'd0);
      drive(1'b1, 32'h00300093, 3'd0, 64'h30, 1'b0, 1'b0);
      drive(1'b1, 32'h00300093, 3'd0, 64'h30, 1'b1, 1'b0);
      drive(1'b1, 32'h00300093, 3'd0, 64'h30, 1'b1, 1'b0);
      idle(3);
      chk("t3_drained", 64'(q32.size()), 64'd0);

      // Test 4: flush while the skid entry is full
      drive(1'b1, 32'h00400093, 3'd0, 64'h40, 1'b0, 1'b0);
      drive(1'b1, 32'h00500093, 3'd0, 64'h50, 1'b0, 1'b0);
      drive(1'b1, 32'h00600093, 3'd0, 64'h60, 1'b0, 1'b1);
      drive(1'b0, 32'd0, 3'd0, 64'd0, 1'b1, 1'b0);
      chk("t4_valid", {63'd0, v32}, 64'd0);
      chk("t4_ready", {63'd0, rdy32}, 64'd1);
      idle(2);

      // Test 6: asynchronous reset in the middle of a cycle while the skid entry is full
      drive(1'b1, 32'hFFF00093, 3'd0, 64'h70, 1'b0, 1'b0);
      drive(1'b1, 32'hFFE00093, 3'd2, 64'h80, 1'b0, 1'b0);
      drive(1'b0, 32'd0, 3'd0, 64'd0, 1'b0, 1'b0);
      chk("t6_pre", {63'd0, rdy32}, 64'd0);
      #2;
      rst_n = 1'b0;
      q32.delete();
      q64.delete();
      #1;
      chk_reset_state("t6");
      #2;
      rst_n = 1'b1;
      send_one(32'h80000037, 3'd3, 64'h1000);
      chk("t6_lat_v", {63'd0, v64}, 64'd1);
      chk("t6_imm64", imm64, 64'hFFFF_FFFF_8000_0000);

      // Random phase
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 3) != 0, $urandom, 3'($urandom_range(0, 7)),
               {$urandom, $urandom}, $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
      end

      // Bounded drain
      idle(6);
      chk("drain32", 64'(q32.size()), 64'd0);
      chk("drain64", 64'(q64.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
